// File: rtl/rej_uniform_sampler_pkg.sv
// Shared constants, state encoding and candidate extraction for the Kyber
// Parse rejection sampler fed by a SHAKE128 squeeze stream.
package rej_uniform_sampler_pkg;

    localparam int BW_DATA    = 64;
    localparam int RATE_WORDS = 21;
    localparam int Q          = 3329;
    localparam int N          = 256;
    localparam int BW_COEFF   = 12;
    localparam int RATE_BITS  = RATE_WORDS * BW_DATA;

    // Sized forms used in comparisons against the counters.
    localparam logic [5:0]          NUM_TRIPLES = 6'(RATE_BITS / 24);
    localparam logic [4:0]          LAST_WORD   = 5'(RATE_WORDS - 1);
    localparam logic [8:0]          LAST_IDX    = 9'(N - 1);
    localparam logic [BW_COEFF-1:0] Q_VAL       = 12'(Q);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PARSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Triple is {b0, b1, b2} with b0 in the top byte.
    // half=0 -> b0 | b1[3:0]<<8, half=1 -> b1[7:4] | b2<<4.
    function automatic logic [BW_COEFF-1:0] parse_candidate(
        input logic [23:0] triple,
        input logic        half
    );
        logic [BW_COEFF-1:0] lo_v;
        logic [BW_COEFF-1:0] hi_v;
        lo_v = {triple[11:8], triple[23:16]};
        hi_v = {triple[7:0], triple[15:12]};
        return half ? hi_v : lo_v;
    endfunction

endpackage

// File: rtl/rej_uniform_sampler.sv
// Kyber Parse: loads one SHAKE128 rate block, scans it for 12-bit candidates
// below Q and emits them as coefficients until N have been handed downstream.
module rej_uniform_sampler
    import rej_uniform_sampler_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic [BW_DATA-1:0]  i_xof_word,
    input  logic                i_xof_valid,
    output logic                o_xof_ready,
    output logic [BW_COEFF-1:0] o_coeff,
    output logic [7:0]          o_coeff_idx,
    output logic                o_coeff_valid,
    input  logic                i_coeff_ready,
    output logic                o_busy,
    output logic                o_done
);

    state_t                state_r;
    logic [RATE_BITS-1:0]  buf_r;
    logic [4:0]            wcnt_r;
    logic [5:0]            tcnt_r;
    logic                  half_r;
    logic [8:0]            ccnt_r;
    logic [BW_COEFF-1:0]   coeff_r;
    logic [7:0]            idx_r;
    logic                  valid_r;
    logic                  done_r;

    logic                  hs_s;
    logic                  stall_s;
    logic                  exhausted_s;
    logic                  last_word_s;
    logic [8:0]            ccnt_next_s;
    logic [5:0]            tsel_s;
    logic [10:0]           tbase_s;
    logic [10:0]           wbase_s;
    logic [23:0]           triple_s;
    logic [BW_COEFF-1:0]   cand_s;
    logic                  cand_ok_s;
    logic [5:0]            tcnt_adv_s;
    logic                  half_adv_s;

    // Handshake decode, candidate selection from the block buffer and the
    // next candidate pointer. The tcnt clamp keeps the part-select in range
    // once the block has been fully scanned.
    always_comb begin
        hs_s        = valid_r & i_coeff_ready;
        stall_s     = valid_r & ~i_coeff_ready;
        ccnt_next_s = hs_s ? (ccnt_r + 9'd1) : ccnt_r;
        exhausted_s = (tcnt_r == NUM_TRIPLES);
        last_word_s = (wcnt_r == LAST_WORD);
        if (tcnt_r < NUM_TRIPLES) begin
            tsel_s = tcnt_r;
        end else begin
            tsel_s = 6'd0;
        end
        tbase_s    = 11'(RATE_BITS - 1) - (11'd24 * 11'(tsel_s));
        wbase_s    = 11'(RATE_BITS - 1) - (11'(BW_DATA) * 11'(wcnt_r));
        triple_s   = buf_r[tbase_s -: 24];
        cand_s     = parse_candidate(triple_s, half_r);
        cand_ok_s  = (cand_s < Q_VAL);
        half_adv_s = ~half_r;
        tcnt_adv_s = half_r ? (tcnt_r + 6'd1) : tcnt_r;
    end

    // Control FSM, block buffer and registered coefficient/done outputs.
    // The first candidate is evaluated on the same edge that accepts the
    // last word, since word 0 (holding triple 0) is already in the buffer.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r <= S_IDLE;
            buf_r   <= '0;
            wcnt_r  <= 5'd0;
            tcnt_r  <= 6'd0;
            half_r  <= 1'b0;
            ccnt_r  <= 9'd0;
            coeff_r <= 12'd0;
            idx_r   <= 8'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        state_r <= S_LOAD;
                        wcnt_r  <= 5'd0;
                        tcnt_r  <= 6'd0;
                        half_r  <= 1'b0;
                        ccnt_r  <= 9'd0;
                    end
                end
                S_LOAD: begin
                    if (i_xof_valid) begin
                        buf_r[wbase_s -: BW_DATA] <= i_xof_word;
                        if (last_word_s) begin
                            state_r <= S_PARSE;
                            wcnt_r  <= 5'd0;
                            coeff_r <= cand_s;
                            idx_r   <= ccnt_r[7:0];
                            valid_r <= cand_ok_s;
                            half_r  <= half_adv_s;
                            tcnt_r  <= tcnt_adv_s;
                        end else begin
                            wcnt_r <= wcnt_r + 5'd1;
                        end
                    end
                end
                S_PARSE: begin
                    if (hs_s && (ccnt_r == LAST_IDX)) begin
                        // Final coefficient taken: rest of the block is dropped.
                        state_r <= S_DONE;
                        ccnt_r  <= ccnt_next_s;
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (!stall_s) begin
                        ccnt_r <= ccnt_next_s;
                        if (exhausted_s) begin
                            state_r <= S_LOAD;
                            valid_r <= 1'b0;
                            wcnt_r  <= 5'd0;
                            tcnt_r  <= 6'd0;
                            half_r  <= 1'b0;
                        end else begin
                            coeff_r <= cand_s;
                            idx_r   <= ccnt_next_s[7:0];
                            valid_r <= cand_ok_s;
                            half_r  <= half_adv_s;
                            tcnt_r  <= tcnt_adv_s;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    ccnt_r  <= 9'd0;
                    wcnt_r  <= 5'd0;
                    tcnt_r  <= 6'd0;
                    half_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign o_coeff       = coeff_r;
    assign o_coeff_idx   = idx_r;
    assign o_coeff_valid = valid_r;
    assign o_done        = done_r;
    assign o_xof_ready   = (state_r == S_LOAD);
    assign o_busy        = (state_r != S_IDLE);

endmodule
